// File: rtl/chip_ctrl_pkg.sv
// Shared command/state types and default pad timing for the chip sequencer.
package chip_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SEED  = 2'd1,
        OP_INFER = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_SETUP  = 4'd1,
        W_PULSE  = 4'd2,
        W_HOLD   = 4'd3,
        SEED     = 4'd4,
        INFER    = 4'd5,
        R_SETUP  = 4'd6,
        R_SAMPLE = 4'd7,
        RESP     = 4'd8
    } state_e;

    localparam int T_SETUP_DEF  = 2;
    localparam int T_PULSE_DEF  = 4;
    localparam int T_HOLD_DEF   = 2;
    localparam int T_SAMPLE_DEF = 3;
    localparam int CW_DEF       = 8;

endpackage

// File: rtl/chip_ports.sv
// Pad-level chip interface: the sequencer drives everything except bit_out.
interface chip_ports;
    logic [7:0] row_addr;
    logic [7:0] col_addr;
    logic       cbl;
    logic       cblen;
    logic       cwl;
    logic       load_mem;
    logic [7:0] seeds;
    logic       load_seed;
    logic       clk;
    logic       inference;
    logic       stoch_log;
    logic       read_1;
    logic       read_8;
    logic       read_out;
    logic [3:0] bit_out;

    modport Master (
        output row_addr, col_addr, cbl, cblen, cwl, load_mem, seeds, load_seed,
               clk, inference, stoch_log, read_1, read_8, read_out,
        input  bit_out
    );

    modport Slave (
        input  row_addr, col_addr, cbl, cblen, cwl, load_mem, seeds, load_seed,
               clk, inference, stoch_log, read_1, read_8, read_out,
        output bit_out
    );
endinterface

// File: rtl/chip_phase_timer.sv
// Loadable down-counter timing each sequencer phase; done while the count is zero.
module chip_phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] val_i,
    input  logic          en_i,
    output logic          done_o
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/chip_sequencer.sv
// Host-side chip sequencer: runs one WRITE/SEED/INFER/READ command at a time on the
// chip pads. Handshakes: a transfer happens on a cycle where valid & ready are both high.
module chip_sequencer
    import chip_ctrl_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_PULSE  = T_PULSE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_SAMPLE = T_SAMPLE_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  op_e        cmd_op,
    input  logic [7:0] cmd_row,
    input  logic [7:0] cmd_col,
    input  logic [7:0] cmd_data,
    input  logic       cmd_flag,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       busy,
    output state_e     dbg_state_o,
    chip_ports.Master  chip
);
    state_e     state_q;
    logic [7:0] row_q;
    logic [7:0] col_q;
    logic       cbl_q;
    logic       cblen_q;
    logic       cwl_q;
    logic       load_mem_q;
    logic [7:0] seeds_q;
    logic       load_seed_q;
    logic       chip_clk_q;
    logic       inference_q;
    logic       stoch_q;
    logic       read_1_q;
    logic       read_8_q;
    logic       read_out_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_data_q;

    logic          accept;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_done;

    assign cmd_ready   = (state_q == IDLE) && !rsp_valid_q;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

    assign chip.row_addr  = row_q;
    assign chip.col_addr  = col_q;
    assign chip.cbl       = cbl_q;
    assign chip.cblen     = cblen_q;
    assign chip.cwl       = cwl_q;
    assign chip.load_mem  = load_mem_q;
    assign chip.seeds     = seeds_q;
    assign chip.load_seed = load_seed_q;
    assign chip.clk       = chip_clk_q;
    assign chip.inference = inference_q;
    assign chip.stoch_log = stoch_q;
    assign chip.read_1    = read_1_q;
    assign chip.read_8    = read_8_q;
    assign chip.read_out  = read_out_q;

    // Timer is reloaded on the same edge the FSM enters a timed phase (value T-1).
    // During INFER it counts chip-clock rising edges, decrementing on each high phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    case (cmd_op)
                        OP_WRITE: tmr_val = CW'(T_SETUP - 1);
                        OP_SEED:  tmr_val = CW'(1);
                        OP_INFER: tmr_val = CW'(cmd_data - 8'd1);
                        OP_READ:  tmr_val = '0;
                    endcase
                end
            end
            W_SETUP: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(T_PULSE - 1);
                end
            end
            W_PULSE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(T_HOLD - 1);
                end
            end
            R_SETUP: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(T_SAMPLE - 1);
                end
            end
            W_HOLD, SEED, R_SAMPLE: tmr_en = 1'b1;
            INFER:                  tmr_en = chip_clk_q;
            default:                tmr_en = 1'b0;
        endcase
    end

    chip_phase_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cbl_q       <= 1'b0;
            cblen_q     <= 1'b0;
            cwl_q       <= 1'b0;
            load_mem_q  <= 1'b0;
            seeds_q     <= '0;
            load_seed_q <= 1'b0;
            chip_clk_q  <= 1'b0;
            inference_q <= 1'b0;
            stoch_q     <= 1'b0;
            read_1_q    <= 1'b0;
            read_8_q    <= 1'b0;
            read_out_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                state_q    <= W_SETUP;
                                row_q      <= cmd_row;
                                col_q      <= cmd_col;
                                cbl_q      <= cmd_data[0];
                                cblen_q    <= 1'b1;
                                load_mem_q <= 1'b1;
                            end
                            OP_SEED: begin
                                state_q     <= SEED;
                                seeds_q     <= cmd_data;
                                load_seed_q <= 1'b1;
                            end
                            OP_INFER: begin
                                state_q     <= INFER;
                                inference_q <= 1'b1;
                                stoch_q     <= cmd_flag;
                            end
                            OP_READ: begin
                                state_q  <= R_SETUP;
                                row_q    <= cmd_row;
                                col_q    <= cmd_col;
                                read_8_q <= cmd_flag;
                                read_1_q <= !cmd_flag;
                            end
                        endcase
                    end
                end
                W_SETUP: begin
                    if (tmr_done) begin
                        state_q <= W_PULSE;
                        cwl_q   <= 1'b1;
                    end
                end
                W_PULSE: begin
                    if (tmr_done) begin
                        state_q <= W_HOLD;
                        cwl_q   <= 1'b0;
                    end
                end
                W_HOLD: begin
                    if (tmr_done) begin
                        state_q    <= IDLE;
                        row_q      <= '0;
                        col_q      <= '0;
                        cbl_q      <= 1'b0;
                        cblen_q    <= 1'b0;
                        load_mem_q <= 1'b0;
                    end
                end
                SEED: begin
                    if (tmr_done) begin
                        state_q     <= IDLE;
                        load_seed_q <= 1'b0;
                        chip_clk_q  <= 1'b0;
                    end else begin
                        chip_clk_q <= 1'b1;
                    end
                end
                INFER: begin
                    if (!chip_clk_q) begin
                        chip_clk_q <= 1'b1;
                    end else begin
                        chip_clk_q <= 1'b0;
                        if (tmr_done) begin
                            state_q     <= IDLE;
                            inference_q <= 1'b0;
                            stoch_q     <= 1'b0;
                        end
                    end
                end
                R_SETUP: begin
                    if (tmr_done) begin
                        state_q    <= R_SAMPLE;
                        read_out_q <= 1'b1;
                    end
                end
                R_SAMPLE: begin
                    if (tmr_done) begin
                        state_q     <= RESP;
                        rsp_data_q  <= chip.bit_out;
                        rsp_valid_q <= 1'b1;
                        row_q       <= '0;
                        col_q       <= '0;
                        read_1_q    <= 1'b0;
                        read_8_q    <= 1'b0;
                        read_out_q  <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip_sequencer.sv
// Directed + random bench for chip_sequencer; expectations come from per-command timing rules.
module tb_chip_sequencer;
    import chip_ctrl_pkg::*;

    localparam int TS   = 2;
    localparam int TP   = 4;
    localparam int TH   = 2;
    localparam int TSM  = 3;
    localparam int MAXC = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    op_e        cmd_op = OP_WRITE;
    logic [7:0] cmd_row = '0;
    logic [7:0] cmd_col = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_flag = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       busy;
    state_e     dbg_state;

    chip_ports chip();

    chip_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_data    (cmd_data),
        .cmd_flag    (cmd_flag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .dbg_state_o (dbg_state),
        .chip        (chip)
    );

    always #5 clk = ~clk;

    // Chip model: bit_out carries the real cell value only once read_out has been high TSM cycles.
    logic [3:0] rd_val = '0;
    int         ro_cnt = 0;
    always @(negedge clk) ro_cnt <= chip.read_out ? ro_cnt + 1 : 0;
    assign chip.bit_out = (ro_cnt == TSM) ? rd_val : ~rd_val;

    logic any_lines;
    assign any_lines = |{chip.row_addr, chip.col_addr, chip.cbl, chip.cblen, chip.cwl,
                         chip.load_mem, chip.load_seed, chip.clk, chip.inference,
                         chip.stoch_log, chip.read_1, chip.read_8, chip.read_out};

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [7:0] last_seed = '0;
    int         last_wait;

    int n_busy, n_cblen, n_cbl, n_lmem, n_cwl, cwl_first, cwl_last, n_rise, n_lseed;
    int n_inf, n_stoch, n_r1, n_r8, n_rout, rout_first, n_resp, bad_addr, bad_inv;
    logic idle_lines, finished;

    logic       chain = 1'b0;
    op_e        chain_op = OP_WRITE;
    logic [7:0] chain_row = '0, chain_col = '0, chain_data = '0;
    logic       chain_flag = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input op_e op, input logic [7:0] row, col, data, input logic flag);
        int w = 0;
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data; cmd_flag = flag;
        cmd_valid = 1'b1;
        if (op == OP_READ) exp_q.push_back(rd_val);
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic observe(input logic [7:0] row, col, input int hold);
        logic prev_clk = 1'b0;
        n_busy = 0; n_cblen = 0; n_cbl = 0; n_lmem = 0; n_cwl = 0; cwl_first = 0; cwl_last = 0;
        n_rise = 0; n_lseed = 0; n_inf = 0; n_stoch = 0; n_r1 = 0; n_r8 = 0; n_rout = 0;
        rout_first = 0; n_resp = 0; bad_addr = 0; bad_inv = 0; idle_lines = 1'b1; finished = 1'b0;
        for (int cyc = 1; cyc <= MAXC && !finished; cyc++) begin
            @(negedge clk);
            if (!busy) begin
                finished   = 1'b1;
                idle_lines = any_lines;
            end else begin
                n_busy++;
                if (chip.cblen)     n_cblen++;
                if (chip.cbl)       n_cbl++;
                if (chip.load_mem)  n_lmem++;
                if (chip.load_seed) n_lseed++;
                if (chip.inference) n_inf++;
                if (chip.stoch_log) n_stoch++;
                if (chip.read_1)    n_r1++;
                if (chip.read_8)    n_r8++;
                if (chip.cwl) begin
                    n_cwl++;
                    if (cwl_first == 0) cwl_first = cyc;
                    cwl_last = cyc;
                end
                if (chip.read_out) begin
                    n_rout++;
                    if (rout_first == 0) rout_first = cyc;
                end
                if (chip.clk && !prev_clk) n_rise++;
                prev_clk = chip.clk;
                if ((chip.cblen || chip.read_1 || chip.read_8) &&
                    (chip.row_addr !== row || chip.col_addr !== col)) bad_addr++;
                if (cmd_ready) bad_inv++;
                if (chip.read_1 && chip.read_8) bad_inv++;
                if ((chip.cwl || chip.cbl || chip.load_mem) && !chip.cblen) bad_inv++;
                if (chip.clk && !(chip.load_seed || chip.inference)) bad_inv++;
                if (rsp_valid) begin
                    n_resp++;
                    if (any_lines) bad_inv++;
                    if (n_resp == 1) begin
                        check("rsp_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check("rsp_data", rsp_data, exp_q.pop_front());
                    end
                    if (n_resp > hold) rsp_ready = 1'b1;
                end
            end
        end
        check("cmd_timeout", finished, 1'b1);
        rsp_ready = 1'b0;
    endtask

    task automatic run(input op_e op, input logic [7:0] row, col, data, input logic flag,
                       input int hold, input logic [3:0] rval);
        int e_busy = 0, e_cblen = 0, e_cbl = 0, e_lmem = 0, e_cwl = 0, e_cf = 0, e_cl = 0;
        int e_rise = 0, e_lseed = 0, e_inf = 0, e_stoch = 0, e_r1 = 0, e_r8 = 0, e_rout = 0;
        int e_rf = 0, e_resp = 0, n;
        rd_val = rval;
        send(op, row, col, data, flag);
        if (chain) begin
            cmd_op = chain_op; cmd_row = chain_row; cmd_col = chain_col;
            cmd_data = chain_data; cmd_flag = chain_flag; cmd_valid = 1'b1;
        end
        observe(row, col, hold);
        case (op)
            OP_WRITE: begin
                e_busy = TS + TP + TH; e_cblen = e_busy; e_lmem = e_busy;
                e_cbl = data[0] ? e_busy : 0;
                e_cwl = TP; e_cf = TS + 1; e_cl = TS + TP;
            end
            OP_SEED: begin
                e_busy = 2; e_lseed = 2; e_rise = 1; last_seed = data;
            end
            OP_INFER: begin
                n = (data == 8'd0) ? 256 : int'(data);
                e_busy = 2 * n; e_rise = n; e_inf = 2 * n; e_stoch = flag ? 2 * n : 0;
            end
            OP_READ: begin
                e_busy = 1 + TSM + hold + 1; e_rout = TSM; e_rf = 2; e_resp = hold + 1;
                e_r8 = flag ? 1 + TSM : 0; e_r1 = flag ? 0 : 1 + TSM;
            end
        endcase
        check("accept_wait", last_wait, 0);
        check("busy_cycles", n_busy, e_busy);
        check("cblen_cycles", n_cblen, e_cblen);
        check("cbl_cycles", n_cbl, e_cbl);
        check("load_mem_cycles", n_lmem, e_lmem);
        check("cwl_cycles", n_cwl, e_cwl);
        check("cwl_first", cwl_first, e_cf);
        check("cwl_last", cwl_last, e_cl);
        check("chip_clk_rises", n_rise, e_rise);
        check("load_seed_cycles", n_lseed, e_lseed);
        check("inference_cycles", n_inf, e_inf);
        check("stoch_log_cycles", n_stoch, e_stoch);
        check("read_1_cycles", n_r1, e_r1);
        check("read_8_cycles", n_r8, e_r8);
        check("read_out_cycles", n_rout, e_rout);
        check("read_out_first", rout_first, e_rf);
        check("rsp_valid_cycles", n_resp, e_resp);
        check("addr_errors", bad_addr, 0);
        check("invariant_errors", bad_inv, 0);
        check("idle_lines", idle_lines, 1'b0);
        check("seeds_hold", chip.seeds, last_seed);
    endtask

    op_e        rop;
    logic [7:0] rdata;

    initial begin
        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        check("rst_lines", any_lines, 1'b0);
        check("rst_seeds", chip.seeds, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 4'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #1 check("rst_release_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // Reset in the middle of the write pulse.
        send(OP_WRITE, 8'h55, 8'h66, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_pulse_cwl", chip.cwl, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cwl", chip.cwl, 1'b0);
        check("async_rst_cblen", chip.cblen, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_ready", cmd_ready, 1'b1);
        last_seed = '0;
        @(negedge clk);

        run(OP_WRITE, 8'h12, 8'h34, 8'h01, 1'b0, 0, 4'h0);
        run(OP_SEED,  8'h00, 8'h00, 8'hA5, 1'b0, 0, 4'h0);
        run(OP_INFER, 8'h00, 8'h00, 8'd5,  1'b1, 0, 4'h0);
        run(OP_INFER, 8'h00, 8'h00, 8'd0,  1'b0, 0, 4'h0);
        run(OP_READ,  8'h0C, 8'h3D, 8'h00, 1'b1, 10, 4'h9);
        run(OP_READ,  8'hF0, 8'h0F, 8'h00, 1'b0, 0, 4'h6);

        // Back-to-back: READ held valid throughout the WRITE.
        chain = 1'b1;
        chain_op = OP_READ; chain_row = 8'h21; chain_col = 8'h43; chain_data = 8'h00; chain_flag = 1'b1;
        run(OP_WRITE, 8'hA1, 8'hB2, 8'h00, 1'b0, 0, 4'h0);
        chain = 1'b0;
        check("b2b_ready_first_idle", cmd_ready, 1'b1);
        run(OP_READ, 8'h21, 8'h43, 8'h00, 1'b1, 2, 4'h3);

        for (int i = 0; i < 14; i++) begin
            rop = op_e'($urandom_range(0, 3));
            rdata = (rop == OP_INFER) ? 8'($urandom_range(1, 40)) : 8'($urandom);
            run(rop, 8'($urandom), 8'($urandom), rdata, 1'($urandom),
                int'($urandom_range(0, 5)), 4'($urandom));
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
